cam_subarray_driver: RTL
========================

# cam_subarray_driver

Command sequencer that initiates operations on one CAM_Subarray_Exp instance. It accepts one CAM command at a time over a valid/ready port and drives the subarray's pin-level interface for exactly one enabled cycle. For search ops it waits the subarray's result latency, samples `tag_out`, and returns it over a valid/ready response port. It sits between the compute controller and each subarray.

## Interface
- `RESULT_LAT`, default 1: cycles from the end of the issue cycle to a valid `cam_tag_out` sample. Legal range 1..15.

- `CLK` in 1: clock, rising edge.
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_op` in 3: operation mode, passed to the subarray.
- `cmd_addr_select` in 1.
- `cmd_cmp_addr` in 10.
- `cmd_ppg_addr` in 6.
- `cmd_cmp_data` in 2.
- `cmd_ppg_data` in 2.
- `cmd_data` in 32.
- `cmd_update` in 1.
- `cmd_tag` in 32.
- `cmd_acc` in 1.
- `cmd_use_tag` in 1: use the last search result as the update mask.
- `rsp_valid` out 1 / `rsp_ready` in 1 / `rsp_tag` out 32: search result.
- `busy` out 1: state != IDLE.
- Subarray side, all out unless noted: `cam_data_in` 32, `cam_update_signal` 1, `cam_cmp_addr` 10, `cam_ppg_addr` 6, `cam_cmp_data` 2, `cam_ppg_data` 2, `cam_tag_in` 32, `cam_addr_select` 1, `cam_operation_mode` 3, `cam_chip_enable` 1, `cam_acc_en` 1, `cam_tag_out` in 32.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, register all `cmd_*` fields and go to ISSUE.
- ISSUE, one cycle:
  - Drive all `cam_*` outputs from the registered fields; `cam_chip_enable`=1; `cam_acc_en`=registered `cmd_acc`.
  - Ops 000/001 (write/update) return to IDLE; no response is produced.
  - Ops 010–111 go to WAIT with the counter loaded to `RESULT_LAT`.
  - Op 111 is a clear: the subarray drives `tag_out` to 0, and the response is returned normally.
- WAIT:
  - `cam_chip_enable`=0 so the subarray holds `tag_out` and `tag_out_prev`.
  - Decrement the counter each cycle.
  - On the edge ending the last WAIT cycle, capture `cam_tag_out` into `rsp_tag` (and `last_tag`), then go to RESP.
- RESP:
  - `rsp_valid`=1, with `rsp_tag` stable, until `rsp_ready` is high.
  - The handshake edge returns the FSM to IDLE.
- Outside ISSUE, every `cam_*` output is 0.
- `cmd_ready` is registered and is 0 in ISSUE/WAIT/RESP, so only one command is outstanding at a time.
- `cam_acc_en` ORs in the subarray's previous `tag_out`; the controller is responsible for sequencing accumulates.

## Timing
- Reset values: every output 0, including `cmd_ready`, `rsp_tag` and `last_tag`; state IDLE.
- `cmd_ready` rises in the first cycle after reset release.
- Taking the accept cycle as cycle 0:
  - ISSUE is cycle 1.
  - WAIT is cycles 2..`RESULT_LAT`+1.
  - `rsp_valid` is first high in cycle `RESULT_LAT`+2.
- Write throughput: one command per 2 cycles.
- Search throughput: one command per `RESULT_LAT`+3 cycles with `rsp_ready` tied high.
- Reset asserted mid-operation:
  - Immediately returns all outputs to 0.
  - Abandons the in-flight command; no response is ever produced for it.
  - Clears `last_tag`.
- `rsp_ready` high outside RESP is ignored.
- `cmd_valid` outside IDLE is ignored. Fields need only be stable in the accept cycle.

## Configuration
- `CAM_DRV_TAG_FWD_EN` defined:
  - A 32-bit `last_tag` register holds the most recent captured search result.
  - For op 001 with `cmd_use_tag`=1, `cam_tag_in`=`last_tag`; otherwise `cam_tag_in`=`cmd_tag`.
  - This enables search-then-masked-update sequences without a round trip through the controller.
- Undefined:
  - `last_tag` is not built.
  - `cmd_use_tag` is ignored.
  - `cam_tag_in` is always `cmd_tag`.

## Structure
- Shared package `cam_pkg` holds:
  - Op encodings: `OP_WRITE`=000, `OP_UPDATE`=001, `OP_SRCH_CMP`=010, `OP_SRCH_PPG`=011, `OP_SRCH_CMP2`=100, `OP_SRCH_PPG2`=101, `OP_SRCH_MIX`=110, `OP_CLR`=111.
  - The driver FSM state encoding.
  - Width constants (tag 32, cmp_addr 10, ppg_addr 6).
- No sub-module: the latency counter and command register are inline.

## Test plan
All scenarios run with a real CAM_Subarray_Exp attached.
- Write then search: op 000, `cmp_addr`=3, `data`=0xA5A50F0F; then op 010, `cmp_addr`=3, `cmp_data`=1 → `rsp_tag`=0xA5A50F0F. Repeat with `cmp_data`=0 → 0x5A5AF0F0.
- Tag forwarding (macro defined): after the scenario above, op 001 row 3 with `cmd_use_tag`=1 and `update`=1, `last_tag` = 0x5A5AF0F0 (the `cmp_data`=0 result) → row 3 = 0xFFFFFFFF; search `cmp_data`=1 → 0xFFFFFFFF. Without the macro, `cmd_tag`=0 leaves row 3 unchanged.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` held, `rsp_tag` stable, `cmd_ready`=0, `cam_chip_enable`=0 throughout.
- Back-to-back writes: `cmd_valid` held for 4 op-000 commands → exactly 4 single-cycle `cam_chip_enable` pulses on alternate cycles, no `rsp_valid`.
- Latency: with `RESULT_LAT`=3, op 010 accepted at cycle 0 → `rsp_valid` first high in cycle 5. Op 111 → `rsp_tag`=0.
- Reset mid-WAIT (`RESULT_LAT`=3) → all outputs 0 at once; `cmd_ready`=1 in the first cycle after release; no `rsp_valid` afterwards.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared encodings for the CAM subarray driver: opcodes, FSM states, field widths
// and the registered command record.
package cam_pkg;

    localparam int TAG_W      = 32;
    localparam int DATA_W     = 32;
    localparam int CMP_ADDR_W = 10;
    localparam int PPG_ADDR_W = 6;
    localparam int CNT_W      = 4;

    localparam logic [2:0] OP_WRITE     = 3'b000;
    localparam logic [2:0] OP_UPDATE    = 3'b001;
    localparam logic [2:0] OP_SRCH_CMP  = 3'b010;
    localparam logic [2:0] OP_SRCH_PPG  = 3'b011;
    localparam logic [2:0] OP_SRCH_CMP2 = 3'b100;
    localparam logic [2:0] OP_SRCH_PPG2 = 3'b101;
    localparam logic [2:0] OP_SRCH_MIX  = 3'b110;
    localparam logic [2:0] OP_CLR       = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } drv_state_t;

    typedef struct packed {
        logic [2:0]            op;
        logic                  addr_select;
        logic [CMP_ADDR_W-1:0] cmp_addr;
        logic [PPG_ADDR_W-1:0] ppg_addr;
        logic [1:0]            cmp_data;
        logic [1:0]            ppg_data;
        logic [DATA_W-1:0]     data;
        logic                  update;
        logic [TAG_W-1:0]      tag;
        logic                  acc;
    } cam_cmd_t;

    // Writes and updates complete in the issue cycle; every other op returns a tag.
    function automatic logic op_has_result(input logic [2:0] op);
        return !(op == OP_WRITE || op == OP_UPDATE);
    endfunction

endpackage

// File: rtl/cam_subarray_driver.sv
// Single-outstanding command sequencer for one CAM subarray: issue for one cycle,
// wait RESULT_LAT cycles, return the sampled tag. CAM_DRV_TAG_FWD_EN adds last_tag forwarding.
module cam_subarray_driver
    import cam_pkg::*;
#(
    parameter int RESULT_LAT = 1
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic                  cmd_addr_select,
    input  logic [CMP_ADDR_W-1:0] cmd_cmp_addr,
    input  logic [PPG_ADDR_W-1:0] cmd_ppg_addr,
    input  logic [1:0]            cmd_cmp_data,
    input  logic [1:0]            cmd_ppg_data,
    input  logic [DATA_W-1:0]     cmd_data,
    input  logic                  cmd_update,
    input  logic [TAG_W-1:0]      cmd_tag,
    input  logic                  cmd_acc,
    input  logic                  cmd_use_tag,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic                  busy,
    output logic [DATA_W-1:0]     cam_data_in,
    output logic                  cam_update_signal,
    output logic [CMP_ADDR_W-1:0] cam_cmp_addr,
    output logic [PPG_ADDR_W-1:0] cam_ppg_addr,
    output logic [1:0]            cam_cmp_data,
    output logic [1:0]            cam_ppg_data,
    output logic [TAG_W-1:0]      cam_tag_in,
    output logic                  cam_addr_select,
    output logic [2:0]            cam_operation_mode,
    output logic                  cam_chip_enable,
    output logic                  cam_acc_en,
    input  logic [TAG_W-1:0]      cam_tag_out
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RESULT_LAT);

    drv_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    cam_cmd_t         cmd_q, cmd_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

`ifdef CAM_DRV_TAG_FWD_EN
    logic             use_tag_q, use_tag_d;
    logic [TAG_W-1:0] last_tag_q, last_tag_d;
`else
    logic             unused_use_tag;
    assign unused_use_tag = cmd_use_tag;
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            cmd_ready_q <= 1'b0;
            rsp_tag_q   <= '0;
`ifdef CAM_DRV_TAG_FWD_EN
            use_tag_q   <= 1'b0;
            last_tag_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_tag_q   <= rsp_tag_d;
`ifdef CAM_DRV_TAG_FWD_EN
            use_tag_q   <= use_tag_d;
            last_tag_q  <= last_tag_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        rsp_tag_d = rsp_tag_q;
`ifdef CAM_DRV_TAG_FWD_EN
        use_tag_d  = use_tag_q;
        last_tag_d = last_tag_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_d.op          = cmd_op;
                    cmd_d.addr_select = cmd_addr_select;
                    cmd_d.cmp_addr    = cmd_cmp_addr;
                    cmd_d.ppg_addr    = cmd_ppg_addr;
                    cmd_d.cmp_data    = cmd_cmp_data;
                    cmd_d.ppg_data    = cmd_ppg_data;
                    cmd_d.data        = cmd_data;
                    cmd_d.update      = cmd_update;
                    cmd_d.tag         = cmd_tag;
                    cmd_d.acc         = cmd_acc;
`ifdef CAM_DRV_TAG_FWD_EN
                    use_tag_d         = cmd_use_tag;
`endif
                    state_d           = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (op_has_result(cmd_q.op)) begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // The subarray holds tag_out while disabled, so sampling on the last WAIT edge is safe.
                if (cnt_q <= CNT_W'(1)) begin
                    rsp_tag_d = cam_tag_out;
`ifdef CAM_DRV_TAG_FWD_EN
                    last_tag_d = cam_tag_out;
`endif
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_comb begin
        cmd_ready          = cmd_ready_q;
        rsp_valid          = (state_q == ST_RESP);
        rsp_tag            = rsp_tag_q;
        busy               = (state_q != ST_IDLE);
        cam_data_in        = '0;
        cam_update_signal  = 1'b0;
        cam_cmp_addr       = '0;
        cam_ppg_addr       = '0;
        cam_cmp_data       = '0;
        cam_ppg_data       = '0;
        cam_tag_in         = '0;
        cam_addr_select    = 1'b0;
        cam_operation_mode = '0;
        cam_chip_enable    = 1'b0;
        cam_acc_en         = 1'b0;
        if (state_q == ST_ISSUE) begin
            cam_data_in        = cmd_q.data;
            cam_update_signal  = cmd_q.update;
            cam_cmp_addr       = cmd_q.cmp_addr;
            cam_ppg_addr       = cmd_q.ppg_addr;
            cam_cmp_data       = cmd_q.cmp_data;
            cam_ppg_data       = cmd_q.ppg_data;
            cam_addr_select    = cmd_q.addr_select;
            cam_operation_mode = cmd_q.op;
            cam_chip_enable    = 1'b1;
            cam_acc_en         = cmd_q.acc;
`ifdef CAM_DRV_TAG_FWD_EN
            cam_tag_in = (cmd_q.op == OP_UPDATE && use_tag_q) ? last_tag_q : cmd_q.tag;
`else
            cam_tag_in = cmd_q.tag;
`endif
        end
    end

endmodule
